// File: rtl/addr_gen_pkg.sv
// addr_gen_pkg: shared selects, widths and sign-extension helper for the LC-3 address generator
package addr_gen_pkg;
  localparam int OPC_W = 4;
  localparam int NZP_W = 3;
  localparam int IR_W = 16;
  localparam int MAX_W = 64;
  typedef enum logic {A1_PC, A1_SR1} addr1_sel_e;
  typedef enum logic [1:0] {A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11} addr2_sel_e;
  // Sign-extends field[msb_idx:0] to MAX_W bits; callers cast the result down to DATA_W.
  function automatic logic [MAX_W-1:0] sext(input logic [IR_W-1:0] field, input int msb_idx);
    logic [MAX_W-1:0] t;
    t = {field, {(MAX_W-IR_W){1'b0}}} << (IR_W - 1 - msb_idx);
    return $signed(t) >>> (MAX_W - 1 - msb_idx);
  endfunction
endpackage

// File: rtl/addr_gen_pipe_if.sv
// addr_gen_pipe_if: decode-side request and MAR/PC-side result bus of the address generator
interface addr_gen_pipe_if import addr_gen_pkg::*; #(parameter int DATA_W = 16);
  logic flush, in_valid, in_ready, ADDR1MUX, out_valid, out_ready;
  logic [IR_W-1:0] IR;
  logic [1:0] ADDR2MUX;
  logic [DATA_W-1:0] sr1_data, pc_data, ea, sext5;
  logic [OPC_W-1:0] opcode;
  logic [NZP_W-1:0] nzp;
  modport master(output flush, in_valid, IR, ADDR1MUX, ADDR2MUX, sr1_data, pc_data, out_ready,
                 input in_ready, out_valid, ea, sext5, opcode, nzp);
  modport slave(input flush, in_valid, IR, ADDR1MUX, ADDR2MUX, sr1_data, pc_data, out_ready,
                output in_ready, out_valid, ea, sext5, opcode, nzp);
endinterface

// File: rtl/addr_gen_slice.sv
// addr_gen_slice: one valid/ready register slice with load, hold and synchronous flush
module addr_gen_slice #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         adv,
  input  logic         in_valid,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  // Valid bit: flush wins, otherwise it follows the upstream valid whenever the slice advances.
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= 1'b0;
    else if (flush) valid <= 1'b0;
    else if (adv) valid <= in_valid;
  // Payload loads only on a real transfer; a flush leaves the stale value in place.
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (adv & in_valid & !flush) q <= d;
endmodule

// File: rtl/addr_gen_pipe.sv
// addr_gen_pipe: two-stage LC-3 effective-address generator (select, add); ADDRGEN_PERF_CNT_EN adds perf counters
module addr_gen_pipe import addr_gen_pkg::*; #(
  parameter int DATA_W = 16
`ifdef ADDRGEN_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic Clk,
  input logic Reset,
  addr_gen_pipe_if.slave bus
`ifdef ADDRGEN_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_beats
  , output logic [CNT_W-1:0] perf_stall
`endif
);
  localparam int S1_W = 3 * DATA_W + OPC_W + NZP_W;
  localparam int S2_W = 2 * DATA_W + OPC_W + NZP_W;
  logic s1_valid, s2_valid, s1_adv, s2_adv;
  logic [S1_W-1:0] s1_q;
  logic [S2_W-1:0] s2_q;
  logic [DATA_W-1:0] base, offset, s1_base, s1_offset, s1_sext5;
  logic [OPC_W-1:0] s1_opcode;
  logic [NZP_W-1:0] s1_nzp;
  // Backpressure chain: a stage moves when it is empty or its successor moves.
  always_comb begin
    s2_adv = !s2_valid | bus.out_ready;
    s1_adv = !s1_valid | s2_adv;
    bus.in_ready = s1_adv & !bus.flush;
    bus.out_valid = s2_valid;
  end
  // Base and offset selection from the decode-stage mux controls.
  always_comb begin
    base = bus.ADDR1MUX == A1_SR1 ? bus.sr1_data : bus.pc_data;
    offset = bus.ADDR2MUX == A2_OFF6  ? DATA_W'(sext(bus.IR, 5)) :
             bus.ADDR2MUX == A2_OFF9  ? DATA_W'(sext(bus.IR, 8)) :
             bus.ADDR2MUX == A2_OFF11 ? DATA_W'(sext(bus.IR, 10)) : '0;
  end
  addr_gen_slice #(.W(S1_W)) u_s1 (
    .clk(Clk), .rst(Reset), .flush(bus.flush), .adv(s1_adv),
    .in_valid(bus.in_valid & bus.in_ready),
    .d({base, offset, DATA_W'(sext(bus.IR, 4)), bus.IR[15:12], bus.IR[11:9]}),
    .valid(s1_valid), .q(s1_q)
  );
  // Unpack S1 and present S2 on the result bus.
  always_comb begin
    {s1_base, s1_offset, s1_sext5, s1_opcode, s1_nzp} = s1_q;
    {bus.ea, bus.sext5, bus.opcode, bus.nzp} = s2_q;
  end
  addr_gen_slice #(.W(S2_W)) u_s2 (
    .clk(Clk), .rst(Reset), .flush(bus.flush), .adv(s2_adv), .in_valid(s1_valid),
    .d({s1_base + s1_offset, s1_sext5, s1_opcode, s1_nzp}),
    .valid(s2_valid), .q(s2_q)
  );
`ifdef ADDRGEN_PERF_CNT_EN
  // Saturating completed-beat and stall-cycle counters, cleared only by Reset.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else begin
      if (s2_valid & bus.out_ready & ~&perf_beats) perf_beats <= perf_beats + 1'b1;
      if (s2_valid & !bus.out_ready & ~&perf_stall) perf_stall <= perf_stall + 1'b1;
    end
`endif
endmodule

// File: tb/tb_addr_gen_pipe.sv
// tb_addr_gen_pipe: table-driven check of addr_gen_pipe plus flush, backpressure and reset sequences
module tb_addr_gen_pipe;
  logic Clk = 1'b0, Reset = 1'b1;
  int checks = 0, errors = 0;
  addr_gen_pipe_if #(.DATA_W(16)) bus ();
`ifdef ADDRGEN_PERF_CNT_EN
  logic [15:0] perf_beats, perf_stall;
`endif
  addr_gen_pipe #(.DATA_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus.slave)
`ifdef ADDRGEN_PERF_CNT_EN
    , .perf_beats(perf_beats), .perf_stall(perf_stall)
`endif
  );
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] ir;
    logic        a1;
    logic [1:0]  a2;
    logic [15:0] sr1, pc, ea, s5;
    logic [3:0]  opc;
    logic [2:0]  nzp;
  } vec_t;
  vec_t tv[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [15:0] ir, input logic a1, input logic [1:0] a2,
                       input logic [15:0] sr1, input logic [15:0] pc);
    bus.IR = ir; bus.ADDR1MUX = a1; bus.ADDR2MUX = a2; bus.sr1_data = sr1; bus.pc_data = pc;
  endtask

  initial begin
    int sent, got;
    bit saw_block;
    logic [15:0] held;
    tv[0] = '{16'h0E05, 1'b0, 2'd2, 16'h0000, 16'h3000, 16'h3005, 16'h0005, 4'h0, 3'b111};
    tv[1] = '{16'h01F8, 1'b0, 2'd2, 16'h0000, 16'h3000, 16'h2FF8, 16'hFFF8, 4'h0, 3'b000};
    tv[2] = '{16'h003F, 1'b1, 2'd1, 16'h0004, 16'h3000, 16'h0003, 16'hFFFF, 4'h0, 3'b000};
    tv[3] = '{16'h6000, 1'b1, 2'd0, 16'h1234, 16'h5555, 16'h1234, 16'h0000, 4'h6, 3'b000};
    tv[4] = '{16'h4FFF, 1'b0, 2'd3, 16'h0000, 16'h4000, 16'h3FFF, 16'hFFFF, 4'h4, 3'b111};
    tv[5] = '{16'h43FF, 1'b0, 2'd3, 16'h0000, 16'h0001, 16'h0400, 16'hFFFF, 4'h4, 3'b001};
    tv[6] = '{16'hA01F, 1'b1, 2'd1, 16'h0100, 16'h0000, 16'h011F, 16'hFFFF, 4'hA, 3'b000};
    tv[7] = '{16'h0020, 1'b1, 2'd1, 16'h0000, 16'h0000, 16'hFFE0, 16'h0000, 4'h0, 3'b000};
    tv[8] = '{16'h0001, 1'b1, 2'd3, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 4'h0, 3'b000};
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    drive(16'h0, 1'b0, 2'd0, 16'h0, 16'h0);
    repeat (3) @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ea", bus.ea, 0);
    chk("rst_sext5", bus.sext5, 0);
    chk("rst_opcode_nzp", {bus.opcode, bus.nzp}, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // flush with two beats in flight; the beat offered alongside flush is dropped
    drive(16'h0E01, 1'b0, 2'd2, 16'h0, 16'h0100); bus.in_valid = 1;
    @(negedge Clk);
    drive(16'h0E02, 1'b0, 2'd2, 16'h0, 16'h0200);
    @(negedge Clk);
    chk("fl_pre_valid", bus.out_valid, 1);
    chk("fl_pre_ea", bus.ea, 16'h0101);
    bus.flush = 1; bus.out_ready = 0;
    drive(16'h0E03, 1'b0, 2'd2, 16'h0, 16'h0300);
    #1 chk("fl_in_ready", bus.in_ready, 0);
    @(negedge Clk);
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    chk("fl_out_valid", bus.out_valid, 0);
    chk("fl_stale_ea", bus.ea, 16'h0101);
    repeat (3) begin
      @(negedge Clk);
      chk("fl_quiet", bus.out_valid, 0);
    end

    // single beats through an empty pipe
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk);
      drive(tv[i].ir, tv[i].a1, tv[i].a2, tv[i].sr1, tv[i].pc);
      bus.in_valid = 1;
      chk("v_empty", bus.out_valid, 0);
      #1 chk("v_in_ready", bus.in_ready, 1);
      @(negedge Clk);
      bus.in_valid = 0;
      chk("v_lat1", bus.out_valid, 0);
      @(negedge Clk);
      chk("v_valid", bus.out_valid, 1);
      chk($sformatf("v%0d_ea", i), bus.ea, tv[i].ea);
      chk($sformatf("v%0d_sext5", i), bus.sext5, tv[i].s5);
      chk($sformatf("v%0d_opcode", i), bus.opcode, tv[i].opc);
      chk($sformatf("v%0d_nzp", i), bus.nzp, tv[i].nzp);
    end
    @(negedge Clk);
    chk("v_drained", bus.out_valid, 0);

    // five back-to-back beats with out_ready low for cycles 3..5
    sent = 0; got = 0; saw_block = 0; held = '0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      @(negedge Clk);
      bus.out_ready = !(c >= 3 && c <= 5);
      if (sent < 5) begin
        drive(16'h0E00 | 16'(sent), 1'b0, 2'd2, 16'h0, 16'h1000 + 16'(sent * 16));
        bus.in_valid = 1;
      end else bus.in_valid = 0;
      if (c >= 4 && c <= 5) chk("bp_hold_ea", bus.ea, held);
      if (c == 3) held = bus.ea;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp_ea%0d", got), bus.ea, 16'h1000 + 16'(got * 17));
        got++;
      end
      #1;
      if (!bus.in_ready) saw_block = 1;
      if (bus.in_valid && bus.in_ready) sent++;
    end
    chk("bp_count", got, 5);
    chk("bp_in_ready_dropped", saw_block, 1);
    bus.in_valid = 0; bus.out_ready = 1;
    repeat (3) begin
      @(negedge Clk);
      chk("bp_no_dup", bus.out_valid, 0);
    end
`ifdef ADDRGEN_PERF_CNT_EN
    chk("perf_beats", perf_beats, 14);
    chk("perf_stall", perf_stall, 4);
`endif

    // asynchronous reset with a beat in S1
    @(negedge Clk);
    drive(16'h0E07, 1'b0, 2'd2, 16'h0, 16'h0700); bus.in_valid = 1;
    @(negedge Clk);
    bus.in_valid = 0;
    #2 Reset = 1;
    #1 chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_ea", bus.ea, 0);
    @(negedge Clk);
    Reset = 0;
    repeat (3) begin
      @(negedge Clk);
      chk("ar_quiet", bus.out_valid, 0);
    end
`ifdef ADDRGEN_PERF_CNT_EN
    chk("ar_perf_beats", perf_beats, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
